// File: rtl/left_rotate_reg.sv
// DW-bit register with parallel load and single-bit left rotate (MSB wraps to bit 0).
// Priority: async reset > load > rotate enable > hold; q comes straight from the flop.
module left_rotate_reg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);

  // sync_rst is asynchronous despite its name; the port name is kept for existing users.
  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (en) begin
      q <= {q[DW-2:0], q[DW-1]};
    end
  end

endmodule

// File: tb/tb_left_rotate_reg.sv
// Directed and random checks of left_rotate_reg against a rotl1 reference model.
module tb_left_rotate_reg;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic          load;
  logic          en;
  logic [DW-1:0] data;
  logic [DW-1:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  left_rotate_reg #(.DW(DW)) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .load     (load),
    .en       (en),
    .data     (data),
    .q        (q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rotl1(input logic [DW-1:0] v);
    return {v[DW-2:0], v[DW-1]};
  endfunction

  // Advance one rising edge and settle outputs away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    load = 1'b0; en = 1'b0; data = '0;
    sync_rst = 1'b1;
    #2;
    n_checks++;
    if (q !== 4'h0) begin
      n_fail++; $display("FAIL reset_initial: q=%h expected=%h", q, 4'h0);
    end
    step();
    sync_rst = 1'b0;
    // Load a nonzero value so the mid-cycle reset has something to clear.
    load = 1'b1; data = 4'hF;
    step();
    n_checks++;
    if (q !== 4'hF) begin
      n_fail++; $display("FAIL reset_preload: q=%h expected=%h", q, 4'hF);
    end
    #2;
    sync_rst = 1'b1;
    #1;
    n_checks++;
    if (q !== 4'h0) begin
      n_fail++; $display("FAIL reset_async: q=%h expected=%h", q, 4'h0);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (q !== 4'h0) begin
        n_fail++; $display("FAIL reset_held[%0d]: q=%h expected=%h", i, q, 4'h0);
      end
    end
    sync_rst = 1'b0;
    load = 1'b0;
  endtask

  task automatic test_load_hold();
    en = 1'b0; load = 1'b1; data = 4'h9;
    step();
    n_checks++;
    if (q !== 4'h9) begin
      n_fail++; $display("FAIL load: q=%h expected=%h", q, 4'h9);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = 4'($urandom_range(0, 15));
      step();
      n_checks++;
      if (q !== 4'h9) begin
        n_fail++; $display("FAIL hold[%0d]: q=%h expected=%h", i, q, 4'h9);
      end
    end
  endtask

  task automatic test_rotate();
    logic [DW-1:0] exp_seq [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    load = 1'b1; en = 1'b0; data = 4'b1001;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (q !== exp_seq[i]) begin
        n_fail++; $display("FAIL rotate[%0d]: q=%b expected=%b", i, q, exp_seq[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 1'b1; en = 1'b0; data = 4'b0011;
    step();
    en = 1'b1; load = 1'b1; data = 4'hA;
    step();
    n_checks++;
    if (q !== 4'hA) begin
      n_fail++; $display("FAIL load_priority: q=%h expected=%h", q, 4'hA);
    end
    load = 1'b0;
    step();
    n_checks++;
    if (q !== 4'h5) begin
      n_fail++; $display("FAIL rotate_after_load: q=%h expected=%h", q, 4'h5);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_during_rotate();
    logic [DW-1:0] exp_seq [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
    load = 1'b1; en = 1'b1; data = 4'h3;
    step();
    load = 1'b0;
    step();
    step();
    n_checks++;
    if (q !== 4'hC) begin
      n_fail++; $display("FAIL pre_reset_rotate: q=%h expected=%h", q, 4'hC);
    end
    #2;
    sync_rst = 1'b1;
    #1;
    n_checks++;
    if (q !== 4'h0) begin
      n_fail++; $display("FAIL reset_mid_rotate: q=%h expected=%h", q, 4'h0);
    end
    #1;
    sync_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (q !== 4'h0) begin
        n_fail++; $display("FAIL zero_rotate[%0d]: q=%h expected=%h", i, q, 4'h0);
      end
    end
    load = 1'b1; data = 4'h1;
    step();
    n_checks++;
    if (q !== 4'h1) begin
      n_fail++; $display("FAIL reload_one: q=%h expected=%h", q, 4'h1);
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (q !== exp_seq[i]) begin
        n_fail++; $display("FAIL walk_one[%0d]: q=%h expected=%h", i, q, exp_seq[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] model;
    model = q;
    for (int i = 0; i < 50; i++) begin
      load = 1'($urandom_range(0, 1));
      en   = 1'($urandom_range(0, 1));
      data = 4'($urandom_range(0, 15));
      // Guarantee coverage of load+en together and the rotation-invariant values.
      if (i == 3)  begin load = 1'b1; en = 1'b1; data = 4'h6; end
      if (i == 10) begin load = 1'b1; en = 1'b0; data = 4'hF; end
      if (i == 11 || i == 12 || i == 21 || i == 22) begin load = 1'b0; en = 1'b1; end
      if (i == 20) begin load = 1'b1; en = 1'b1; data = 4'h0; end
      if (load)    model = data;
      else if (en) model = rotl1(model);
      step();
      n_checks++;
      if (q !== model) begin
        n_fail++; $display("FAIL random[%0d]: q=%h expected=%h", i, q, model);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  initial begin
    sync_rst = 1'b0; load = 1'b0; en = 1'b0; data = '0;
    @(negedge clk);
    test_reset();
    test_load_hold();
    test_rotate();
    test_load_priority();
    test_reset_during_rotate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
